sram_counter_rmw: RTL

//  Requester-side client of the SRAM arbiter rd/wr port. Accepts counter-increment commands,

---
 rtl/sram_counter_rmw.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/sram_counter_rmw.sv
// Read-modify-write counter client for the SRAM arbiter port: saturating increments of
// 72-bit words, one operation in flight at a time, plus a whole-memory clear sweep.
module sram_counter_rmw #(
  parameter int SRAM_ADDR_WIDTH = 19,
  parameter int SRAM_DATA_WIDTH = 72,
  parameter int DELTA_WIDTH     = 16,
  parameter int RD_TIMEOUT      = 15
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       cmd_vld,
  output logic                       cmd_rdy,
  input  logic [SRAM_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DELTA_WIDTH-1:0]     cmd_delta,
  input  logic                       clr_start,
  output logic                       clr_busy,
  output logic                       rd_req,
  output logic [SRAM_ADDR_WIDTH-1:0] rd_addr,
  input  logic                       rd_ack,
  input  logic                       rd_vld,
  input  logic [SRAM_DATA_WIDTH-1:0] rd_data,
  output logic                       wr_req,
  output logic [SRAM_ADDR_WIDTH-1:0] wr_addr,
  output logic [SRAM_DATA_WIDTH-1:0] wr_data,
  input  logic                       wr_ack,
  output logic [15:0]                sat_cnt,
  output logic                       err_timeout
);

  localparam int TW = $clog2(RD_TIMEOUT + 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_RD_ISSUE  = 3'd1;
  localparam logic [2:0] S_RD_WAIT   = 3'd2;
  localparam logic [2:0] S_WR_ISSUE  = 3'd3;
  localparam logic [2:0] S_CLR_ISSUE = 3'd4;

  localparam logic [SRAM_ADDR_WIDTH-1:0] ADDR_LAST = {SRAM_ADDR_WIDTH{1'b1}};
  localparam logic [SRAM_DATA_WIDTH-1:0] DATA_ONES = {SRAM_DATA_WIDTH{1'b1}};
  localparam logic [SRAM_DATA_WIDTH-1:0] DATA_ZERO = {SRAM_DATA_WIDTH{1'b0}};
  localparam logic [TW-1:0]              TIMER_MAX = TW'(RD_TIMEOUT);

  logic [2:0]                 r_state;
  logic                       r_rd_pend;
  logic                       r_wr_pend;
  logic                       r_cmd_rdy;
  logic                       r_clr_busy;
  logic [SRAM_ADDR_WIDTH-1:0] r_addr;
  logic [DELTA_WIDTH-1:0]     r_delta;
  logic [TW-1:0]              r_timer;
  logic [SRAM_ADDR_WIDTH-1:0] r_wr_addr;
  logic [SRAM_DATA_WIDTH-1:0] r_wr_data;
  logic [15:0]                r_sat_cnt;
  logic                       r_err_timeout;

  logic [SRAM_DATA_WIDTH:0]   w_sum;
  logic                       w_sat;

  // One-bit-wider sum so a carry out of the word marks saturation
  always_comb begin
    w_sum = {1'b0, rd_data} + {{(SRAM_DATA_WIDTH + 1 - DELTA_WIDTH){1'b0}}, r_delta};
    w_sat = w_sum[SRAM_DATA_WIDTH];
  end

  // The ack drops the request in the same cycle so each access is presented exactly once
  assign rd_req      = r_rd_pend & ~rd_ack;
  assign wr_req      = r_wr_pend & ~wr_ack;
  assign rd_addr     = r_addr;
  assign wr_addr     = r_wr_addr;
  assign wr_data     = r_wr_data;
  assign cmd_rdy     = r_cmd_rdy;
  assign clr_busy    = r_clr_busy;
  assign sat_cnt     = r_sat_cnt;
  assign err_timeout = r_err_timeout;

  // Control FSM with pending flags, sweep address, saturation and timeout bookkeeping
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_rd_pend     <= 1'b0;
      r_wr_pend     <= 1'b0;
      r_cmd_rdy     <= 1'b0;
      r_clr_busy    <= 1'b0;
      r_addr        <= {SRAM_ADDR_WIDTH{1'b0}};
      r_delta       <= {DELTA_WIDTH{1'b0}};
      r_timer       <= {TW{1'b0}};
      r_wr_addr     <= {SRAM_ADDR_WIDTH{1'b0}};
      r_wr_data     <= DATA_ZERO;
      r_sat_cnt     <= 16'h0000;
      r_err_timeout <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (clr_start) begin
            r_state    <= S_CLR_ISSUE;
            r_wr_pend  <= 1'b1;
            r_wr_addr  <= {SRAM_ADDR_WIDTH{1'b0}};
            r_wr_data  <= DATA_ZERO;
            r_clr_busy <= 1'b1;
            r_cmd_rdy  <= 1'b0;
          end else if (cmd_vld && r_cmd_rdy) begin
            r_state   <= S_RD_ISSUE;
            r_addr    <= cmd_addr;
            r_delta   <= cmd_delta;
            r_rd_pend <= 1'b1;
            r_cmd_rdy <= 1'b0;
          end else begin
            r_cmd_rdy <= 1'b1;
          end
        end
        S_RD_ISSUE: begin
          if (rd_ack) begin
            r_rd_pend <= 1'b0;
            r_timer   <= {TW{1'b0}};
            r_state   <= S_RD_WAIT;
          end
        end
        S_RD_WAIT: begin
          if (rd_vld) begin
            r_wr_data <= w_sat ? DATA_ONES : w_sum[SRAM_DATA_WIDTH-1:0];
            if (w_sat && (r_sat_cnt != 16'hffff)) begin
              r_sat_cnt <= r_sat_cnt + 16'd1;
            end
            r_wr_addr <= r_addr;
            r_wr_pend <= 1'b1;
            r_state   <= S_WR_ISSUE;
          end else if (r_timer == TIMER_MAX) begin
            r_err_timeout <= 1'b1;
            r_cmd_rdy     <= 1'b1;
            r_state       <= S_IDLE;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        S_WR_ISSUE: begin
          if (wr_ack) begin
            r_wr_pend <= 1'b0;
            r_cmd_rdy <= 1'b1;
            r_state   <= S_IDLE;
          end
        end
        S_CLR_ISSUE: begin
          // Pend stays set across acks so the next sweep word is requested right away
          if (wr_ack) begin
            if (r_wr_addr == ADDR_LAST) begin
              r_wr_pend  <= 1'b0;
              r_clr_busy <= 1'b0;
              r_cmd_rdy  <= 1'b1;
              r_state    <= S_IDLE;
            end else begin
              r_wr_addr <= r_wr_addr + SRAM_ADDR_WIDTH'(1);
            end
          end
        end
        default: begin
          r_rd_pend  <= 1'b0;
          r_wr_pend  <= 1'b0;
          r_clr_busy <= 1'b0;
          r_cmd_rdy  <= 1'b1;
          r_state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule
